// File: rtl/lpc_frame_ring_ctrl.sv
// rtl/lpc_frame_ring_ctrl.sv - slot-pointer controller for the LPC frame ring
//
// Owns the write/read slot pointers, occupancy, full/empty and overflow
// accounting for a frame memory of 2^(AW-3) slots of 8 bytes each.
//
// Optional feature macro: RING_STATS_EN
//   defined   : overflow_count (saturating) and frame_total (wrapping) counters
//   undefined : both outputs tied to 0, no counter flops
//
// Ports
//   clock          in   system clock, all state on posedge
//   reset          in   asynchronous, active-low
//   frame_commit   in   pulse: frame fully written into write_slot
//   write_slot     out  slot the capture side writes next (write pointer)
//   write_ready    out  a free slot exists
//   target_addr    out  slot the drain reads (read pointer)
//   read_empty     out  no committed frame available to drain
//   read_done      in   drain level flag; rising edge = current slot sent
//   overflow       out  sticky: a commit was dropped while full
//   overflow_clear in   pulse: clears overflow and overflow_count
//   overflow_count out  dropped-frame count, saturating at 255
//   frame_total    out  committed-frame count, wrapping
module lpc_frame_ring_ctrl #(
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          frame_commit,
  output logic [AW-4:0] write_slot,
  output logic          write_ready,
  output logic [AW-4:0] target_addr,
  output logic          read_empty,
  input  logic          read_done,
  output logic          overflow,
  input  logic          overflow_clear,
  output logic [7:0]    overflow_count,
  output logic [15:0]   frame_total
);

  localparam int SW = AW - 3;
  localparam logic [SW:0]   SLOTS   = {1'b1, {SW{1'b0}}};
  localparam logic [SW:0]   CNT_ONE = (SW + 1)'(1);
  localparam logic [SW-1:0] PTR_ONE = SW'(1);

  logic [SW-1:0] wr_ptr;
  logic [SW-1:0] rd_ptr;
  logic [SW:0]   count;
  logic          done_q;

  logic full;
  logic empty;
  logic done_rise;
  logic consume;
  logic accept;
  logic drop;

  assign full      = (count == SLOTS);
  assign empty     = (count == '0);
  assign done_rise = read_done & ~done_q;
  assign consume   = done_rise & ~empty;
  assign accept    = frame_commit & ~full;
  // full is the pre-edge value, so a same-cycle consume does not rescue the commit
  assign drop      = frame_commit & full;

  assign write_slot  = wr_ptr;
  assign target_addr = rd_ptr;
  assign write_ready = ~full;
  // Combinational so the drain, re-sampling right after raising read_done,
  // sees the slot it just finished as gone rather than restarting it.
  assign read_empty  = empty | done_rise;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      done_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done_q <= read_done;
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (consume) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({accept, consume})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // a drop in the same cycle as a clear wins
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clear) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef RING_STATS_EN
  logic [7:0]  ovf_cnt;
  logic [15:0] total_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_cnt   <= '0;
      total_cnt <= '0;
    end else begin
      if (drop) begin
        if (overflow_clear) begin
          ovf_cnt <= 8'd1;
        end else if (ovf_cnt != 8'hFF) begin
          ovf_cnt <= ovf_cnt + 8'd1;
        end
      end else if (overflow_clear) begin
        ovf_cnt <= '0;
      end
      if (accept) begin
        total_cnt <= total_cnt + 16'd1;
      end
    end
  end

  assign overflow_count = ovf_cnt;
  assign frame_total    = total_cnt;
`else
  assign overflow_count = '0;
  assign frame_total    = '0;
`endif

endmodule

// File: tb/tb_lpc_frame_ring_ctrl.sv
// tb/tb_lpc_frame_ring_ctrl.sv - self-checking bench for lpc_frame_ring_ctrl (AW=5, 4 slots)
module tb_lpc_frame_ring_ctrl;

  localparam int AW    = 5;
  localparam int SLOTS = 4;

  logic          clock;
  logic          reset;
  logic          frame_commit;
  logic [AW-4:0] write_slot;
  logic          write_ready;
  logic [AW-4:0] target_addr;
  logic          read_empty;
  logic          read_done;
  logic          overflow;
  logic          overflow_clear;
  logic [7:0]    overflow_count;
  logic [15:0]   frame_total;

  lpc_frame_ring_ctrl #(.AW(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .frame_commit   (frame_commit),
    .write_slot     (write_slot),
    .write_ready    (write_ready),
    .target_addr    (target_addr),
    .read_empty     (read_empty),
    .read_done      (read_done),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .overflow_count (overflow_count),
    .frame_total    (frame_total)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queue of committed slot numbers plus plain counters.
  int mq[$];
  int m_wr;
  int m_rd;
  int m_total;
  int m_ocnt;
  bit m_ovf;
  bit m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_ocnt();
`ifdef RING_STATS_EN
    return m_ocnt;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_total();
`ifdef RING_STATS_EN
    return m_total;
`else
    return 0;
`endif
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".write_slot"},     write_slot,     m_wr);
    check({tag, ".target_addr"},    target_addr,    m_rd);
    check({tag, ".write_ready"},    write_ready,    mq.size() < SLOTS);
    check({tag, ".read_empty"},     read_empty,     mq.size() == 0);
    check({tag, ".overflow"},       overflow,       m_ovf);
    check({tag, ".overflow_count"}, overflow_count, exp_ocnt());
    check({tag, ".frame_total"},    frame_total,    exp_total());
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    frame_commit = 1'b0;
    read_done = 1'b0;
    overflow_clear = 1'b0;
    mq.delete();
    m_wr = 0; m_rd = 0; m_total = 0; m_ocnt = 0; m_ovf = 0; m_done = 0;
    #1;
    check_state("reset");
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic step(input bit c, input bit d, input bit clr);
    bit rise;
    bit empty_pre;
    bit full_pre;
    @(negedge clock);
    frame_commit = c;
    read_done = d;
    overflow_clear = clr;
    #1;
    rise = d && !m_done;
    empty_pre = (mq.size() == 0);
    full_pre = (mq.size() == SLOTS);
    check("read_empty_comb", read_empty, empty_pre || rise);
    @(posedge clock);
    if (clr) begin
      m_ovf = 0;
      m_ocnt = 0;
    end
    if (c) begin
      if (full_pre) begin
        m_ovf = 1;
        if (m_ocnt < 255) m_ocnt++;
      end else begin
        mq.push_back(m_wr);
        m_wr = (m_wr + 1) % SLOTS;
        m_total = (m_total + 1) % 65536;
      end
    end
    if (rise && !empty_pre) begin
      void'(mq.pop_front());
      m_rd = (m_rd + 1) % SLOTS;
    end
    m_done = d;
    #1;
    check_state("cycle");
  endtask

  initial begin
    reset = 1'b0;
    frame_commit = 1'b0;
    read_done = 1'b0;
    overflow_clear = 1'b0;

    // 1: reset state
    do_reset();
    check("t1.write_ready", write_ready, 1);
    check("t1.read_empty",  read_empty,  1);
    check("t1.write_slot",  write_slot,  0);
    check("t1.target_addr", target_addr, 0);
    check("t1.overflow",    overflow,    0);

    // 2: single commit then drain
    step(1, 0, 0);
    check("t2.write_slot", write_slot, 1);
    check("t2.read_empty", read_empty, 0);
    step(0, 1, 0);
    check("t2.target_addr", target_addr, 1);
    check("t2.read_empty",  read_empty,  1);
    step(0, 0, 0);

    // 3: five commits, no drain
    do_reset();
    repeat (4) step(1, 0, 0);
    check("t3.write_ready_full", write_ready, 0);
    step(1, 0, 0);
    check("t3.overflow",   overflow,   1);
    check("t3.write_slot", write_slot, 0);
`ifdef RING_STATS_EN
    check("t3.overflow_count", overflow_count, 1);
    check("t3.frame_total",    frame_total,    4);
`else
    check("t3.overflow_count", overflow_count, 0);
    check("t3.frame_total",    frame_total,    0);
`endif

    // 4: full ring, commit and read_done rise together
    step(1, 1, 0);
    check("t4.write_ready", write_ready, 1);
    check("t4.target_addr", target_addr, 1);
`ifdef RING_STATS_EN
    check("t4.overflow_count", overflow_count, 2);
`endif
    step(0, 0, 0);

    // 5: level-high read_done consumes exactly once
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (10) step(0, 1, 0);
    check("t5.one_consume_empty", read_empty, 0);
    check("t5.one_consume_rd",    target_addr, 1);
    step(0, 0, 0);
    step(0, 1, 0);
    check("t5.drained", read_empty, 1);
    step(0, 0, 0);
    step(0, 1, 0);
    check("t5.spurious_rd", target_addr, 2);
    step(0, 0, 0);

    // 6: saturating overflow count, clear, clear vs drop
    do_reset();
    repeat (4) step(1, 0, 0);
    repeat (260) step(1, 0, 0);
`ifdef RING_STATS_EN
    check("t6.sat", overflow_count, 255);
`else
    check("t6.sat", overflow_count, 0);
`endif
    step(0, 0, 1);
    check("t6.clear_ovf", overflow, 0);
    check("t6.clear_cnt", overflow_count, 0);
    step(1, 0, 1);
    check("t6.set_wins", overflow, 1);
`ifdef RING_STATS_EN
    check("t6.set_wins_cnt", overflow_count, 1);
`endif

    // randomized traffic against the model, with a mid-run reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit c;
      bit d;
      bit clr;
      c = ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 2) == 0) ? ~m_done : m_done;
      clr = ($urandom_range(0, 15) == 0);
      step(c, d, clr);
      if (i == 200) do_reset();
    end
    step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
